// File: rtl/dct_quant_slave.sv
// dct_quant_slave: Avalon-MM quantizer for 8 DCT coefficients using one shared multiplier.
// Computes q[i] = sat16((coef[i] * recip[i] + half) >>> FRAC_BITS), one element per cycle.
module dct_quant_slave #(
    parameter int FRAC_BITS = 16
) (
    input  logic        csi_clk,
    input  logic        rsi_reset_n,
    input  logic [7:0]  avs_s0_address,
    input  logic        avs_s0_write,
    input  logic [31:0] avs_s0_writedata,
    input  logic        avs_s0_read,
    output logic [31:0] avs_s0_readdata
);
    typedef enum logic {IDLE, CALC} state_t;
    localparam logic signed [33:0] HALF = 34'sd1 <<< (FRAC_BITS - 1);
    state_t state_q, state_d;
    logic [15:0] coef_q [8];
    logic [15:0] recip_q [8];
    logic [15:0] q_q [8];
    logic [2:0] idx_q;
    logic done_q, busy, calc_en, finish;
    logic start, clr_done, coef_we, recip_we, ctrl_we;
    logic signed [33:0] prod, rnd;
    logic [15:0] sat;
    logic [31:0] rdata_d;
    logic unused_wdata;
    assign unused_wdata = ^avs_s0_writedata[31:16];
    assign ctrl_we  = avs_s0_write && avs_s0_address == 8'h10;
    assign start    = ctrl_we && avs_s0_writedata[0] && state_q == IDLE;
    assign clr_done = ctrl_we && avs_s0_writedata[1];
    assign coef_we  = avs_s0_write && !busy && avs_s0_address[7:3] == 5'd0;
    assign recip_we = avs_s0_write && !busy && avs_s0_address[7:3] == 5'd1;
    // recip is zero-extended so the product stays signed x unsigned
    assign prod = $signed(coef_q[idx_q]) * $signed({1'b0, recip_q[idx_q]});
    assign rnd  = (prod + HALF) >>> FRAC_BITS;
    assign sat  = rnd > 34'sd32767 ? 16'h7fff : rnd < -34'sd32768 ? 16'h8000 : rnd[15:0];
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && start) state_d = CALC;
        if (state_q == CALC && idx_q == 3'd7) state_d = IDLE;
    end
    always_comb begin
        busy    = state_q == CALC;
        calc_en = busy;
        finish  = busy && idx_q == 3'd7;
    end
    always_comb begin
        rdata_d = 32'h0;
        if (avs_s0_address[7:3] == 5'd0) rdata_d = {16'h0, q_q[avs_s0_address[2:0]]};
        if (avs_s0_address[7:3] == 5'd1) rdata_d = {16'h0, recip_q[avs_s0_address[2:0]]};
        if (avs_s0_address == 8'h10) rdata_d = {30'h0, done_q, busy};
    end
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            for (int i = 0; i < 8; i++) begin
                coef_q[i]  <= '0;
                recip_q[i] <= '0;
                q_q[i]     <= '0;
            end
            idx_q           <= '0;
            done_q          <= 1'b0;
            avs_s0_readdata <= '0;
        end else begin
            if (coef_we) coef_q[avs_s0_address[2:0]] <= avs_s0_writedata[15:0];
            if (recip_we) recip_q[avs_s0_address[2:0]] <= avs_s0_writedata[15:0];
            if (calc_en) q_q[idx_q] <= sat;
            idx_q  <= start ? 3'd0 : calc_en ? idx_q + 3'd1 : idx_q;
            done_q <= start ? 1'b0 : finish ? 1'b1 : clr_done ? 1'b0 : done_q;
            if (avs_s0_read) avs_s0_readdata <= rdata_d;
        end
    end
endmodule

// File: tb/tb_dct_quant_slave.sv
// tb_dct_quant_slave: directed table-driven bench for dct_quant_slave at FRAC_BITS 16 and 12.
module tb_dct_quant_slave;
    logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [7:0] addr = '0;
    logic [31:0] wdata = '0, rdata16, rdata12;
    int checks = 0, errors = 0;
    typedef struct {
        logic [15:0] coef;
        logic [15:0] recip;
        logic [15:0] exp16;
        logic [15:0] exp12;
    } vec_t;
    vec_t v [8];

    always #5 clk = ~clk;

    dct_quant_slave dut16 (
        .csi_clk(clk), .rsi_reset_n(rst_n), .avs_s0_address(addr), .avs_s0_write(wr_en),
        .avs_s0_writedata(wdata), .avs_s0_read(rd_en), .avs_s0_readdata(rdata16)
    );
    dct_quant_slave #(.FRAC_BITS(12)) dut12 (
        .csi_clk(clk), .rsi_reset_n(rst_n), .avs_s0_address(addr), .avs_s0_write(wr_en),
        .avs_s0_writedata(wdata), .avs_s0_read(rd_en), .avs_s0_readdata(rdata12)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] dat);
        addr = a; wdata = dat; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        addr = a; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic load_table();
        for (int i = 0; i < 8; i++) begin
            wr(8'(i), {16'h0, v[i].coef});
            wr(8'(8 + i), {16'h0, v[i].recip});
        end
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            rd(8'h10);
            n++;
        end while (rdata16[1] !== 1'b1 && n < 40);
        chk("done_wait", rdata16, 32'h2);
    endtask

    task automatic check_q(input string tag);
        for (int i = 0; i < 8; i++) begin
            rd(8'(i));
            chk($sformatf("%s q16[%0d]", tag, i), rdata16, {16'h0, v[i].exp16});
            chk($sformatf("%s q12[%0d]", tag, i), rdata12, {16'h0, v[i].exp12});
        end
    endtask

    task automatic check_zero(input string tag);
        rd(8'h10);
        chk({tag, " status"}, rdata16, 32'h0);
        for (int i = 0; i < 16; i++) begin
            rd(8'(i));
            chk($sformatf("%s reg[%0d]", tag, i), rdata16, 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        v[0] = '{16'd100,   16'h2000, 16'd13,    16'd200};
        v[1] = '{-16'sd100, 16'h2000, -16'sd12,  -16'sd200};
        v[2] = '{16'h8000,  16'hffff, 16'h8001,  16'h8000};
        v[3] = '{16'h7fff,  16'h2000, 16'd4096,  16'h7fff};
        v[4] = '{16'h8000,  16'h2000, -16'sd4096, 16'h8000};
        v[5] = '{16'd1234,  16'h0000, 16'd0,     16'd0};
        v[6] = '{16'h7fff,  16'hffff, 16'h7fff,  16'h7fff};
        v[7] = '{16'd7,     16'h8000, 16'd4,     16'd56};
        repeat (2) @(negedge clk);
        chk("reset rdata16", rdata16, 32'h0);
        chk("reset rdata12", rdata12, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("reset");

        // basic run: busy for 8 cycles after START, done visible on the 9th
        load_table();
        wr(8'h10, 32'h1);
        for (int k = 1; k <= 9; k++) begin
            rd(8'h10);
            chk($sformatf("status T+%0d", k), rdata16, k <= 8 ? 32'h1 : 32'h2);
        end
        check_q("run1");
        for (int i = 0; i < 8; i++) begin
            rd(8'(8 + i));
            chk($sformatf("recip[%0d]", i), rdata16, {16'h0, v[i].recip});
        end

        // second START and a coef write while busy must both be ignored
        wr(8'h10, 32'h1);
        wr(8'h10, 32'h1);
        wr(8'h00, 32'h7fff);
        for (int k = 3; k <= 9; k++) begin
            rd(8'h10);
            chk($sformatf("restart status T+%0d", k), rdata16, k <= 8 ? 32'h1 : 32'h2);
        end
        check_q("run2");
        wr(8'h10, 32'h2);
        rd(8'h10);
        chk("clr_done status", rdata16, 32'h0);
        wr(8'h10, 32'h3);
        rd(8'h10);
        chk("start+clr status", rdata16, 32'h1);
        wait_done();

        // asynchronous reset in the middle of a run
        wr(8'h10, 32'h1);
        rd(8'h10);
        chk("pre-reset status", rdata16, 32'h1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rdata16", rdata16, 32'h0);
        chk("async rdata12", rdata12, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("midreset");
        load_table();
        wr(8'h10, 32'h1);
        wait_done();
        check_q("run3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
